wb_writer: RTL and testbench

Write-back writer for the pipelined CPU. It is the producer side of the register bank's single write port. It accepts completed results from the MEM/WB stage through a valid/ready handshake and buffers them in a small in-order FIFO. It drains one write per cycle into the bank whenever the port is granted, and exposes pending-destination and forwarding information to the ID-stage hazard logic.

---
 rtl/wb_writer_pkg.sv | 25 ++
 rtl/wb_fifo.sv | 87 ++++++++
 rtl/wb_writer.sv | 143 ++++++++++++++
 tb/tb_wb_writer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_writer_pkg.sv
// Shared CPU definitions used by the write-back writer: register-file
// geometry, the buffered write-entry layout and a one-hot decode helper.
package wb_writer_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;
    localparam int REG_COUNT = 32;

    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dest;
        logic [REG_DW-1:0] data;
    } wb_entry_t;

    // One-hot decode of a register number into a register-file-wide mask.
    function automatic logic [REG_COUNT-1:0] reg_onehot(input logic [REG_AW-1:0] r);
        logic [REG_COUNT-1:0] m;
        m = '0;
        m[r] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Generic in-order FIFO of W-bit payloads. Besides the usual head/full/empty
// it exposes every slot with its valid flag and the write pointer, so the
// owner can search all buffered entries by age.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 37
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [W-1:0]               push_data_i,
    input  logic                       pop_i,
    output logic [W-1:0]               head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH)-1:0]   wptr_o,
    output logic [DEPTH-1:0]           valid_o,
    output logic [W-1:0]               mem_o [DEPTH]
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [W-1:0]     mem_q [DEPTH];

    logic pushOk;
    logic popOk;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign pushOk  = push_i && !full_o;
    assign popOk   = pop_i && !empty_o;

    assign head_o  = mem_q[rptr_q];
    assign wptr_o  = wptr_q;
    assign valid_o = valid_q;
    assign mem_o   = mem_q;

    // Next-state for pointers, occupancy and per-slot valid flags; a pop
    // and a push never hit the same slot because a push needs a free slot.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        valid_d = valid_q;
        if (pushOk) begin
            wptr_d          = wptr_q + PW'(1);
            valid_d[wptr_q] = 1'b1;
        end
        if (popOk) begin
            rptr_d          = rptr_q + PW'(1);
            valid_d[rptr_q] = 1'b0;
        end
        case ({pushOk, popOk})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register; reset empties the FIFO by clearing all flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Payload storage; contents are only meaningful where the valid flag is set.
    always_ff @(posedge clk) begin
        if (pushOk) begin
            mem_q[wptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/wb_writer.sv
// Write-back writer: filters and buffers completed results, drains one write
// per granted cycle into the register bank, and publishes pending-destination
// and youngest-value forwarding information to the ID stage.
module wb_writer
    import wb_writer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = REG_AW,
    parameter int DW    = REG_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_regwrite,
    input  logic          in_memtoreg,
    input  logic [AW-1:0] in_dest,
    input  logic [DW-1:0] in_alu,
    input  logic [DW-1:0] in_mem,
    input  logic          wr_grant,
    output logic          wb_we,
    output logic [AW-1:0] wb_dest,
    output logic [DW-1:0] wb_data,
    input  logic [AW-1:0] rd_addr1,
    input  logic [AW-1:0] rd_addr2,
    output logic          fwd_hit1,
    output logic          fwd_hit2,
    output logic [DW-1:0] fwd_data1,
    output logic [DW-1:0] fwd_data2,
    output logic [31:0]   pend_mask,
    output logic [7:0]    drop_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int EW = AW + DW;

    logic          accept;
    logic          enqueue;
    logic          dropped;
    logic [DW-1:0] selData;

    logic          fifoFull;
    logic          fifoEmpty;
    logic [EW-1:0] headRaw;
    logic [PW-1:0] wptr;
    logic [DEPTH-1:0] slotValid;
    logic [EW-1:0] slotRaw [DEPTH];

    wb_entry_t     ent [DEPTH];

    logic [7:0]    dropCnt_q, dropCnt_d;

    assign in_ready = !fifoFull;
    assign accept   = in_valid && !fifoFull;
    assign enqueue  = accept && in_regwrite && (in_dest != REG_ZERO);
    assign dropped  = accept && !enqueue;
    assign selData  = in_memtoreg ? in_mem : in_alu;

    wb_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (enqueue),
        .push_data_i ({in_dest, selData}),
        .pop_i       (wb_we),
        .head_o      (headRaw),
        .full_o      (fifoFull),
        .empty_o     (fifoEmpty),
        .wptr_o      (wptr),
        .valid_o     (slotValid),
        .mem_o       (slotRaw)
    );

    assign wb_we   = !fifoEmpty && wr_grant;
    assign wb_dest = fifoEmpty ? '0 : headRaw[DW +: AW];
    assign wb_data = fifoEmpty ? '0 : headRaw[DW-1:0];

    // Unpack the FIFO slots into typed entries for the lookups below.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent[i].valid = slotValid[i];
            ent[i].dest  = slotRaw[i][DW +: AW];
            ent[i].data  = slotRaw[i][DW-1:0];
        end
    end

    // Youngest-match forwarding: walk back from the newest slot and take the
    // first hit; register zero never forwards.
    always_comb begin
        logic [PW-1:0] idx;
        idx       = '0;
        fwd_hit1  = 1'b0;
        fwd_hit2  = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = wptr - PW'(k + 1);
            if (!fwd_hit1 && ent[idx].valid && (rd_addr1 != REG_ZERO) &&
                (ent[idx].dest == rd_addr1)) begin
                fwd_hit1  = 1'b1;
                fwd_data1 = ent[idx].data;
            end
            if (!fwd_hit2 && ent[idx].valid && (rd_addr2 != REG_ZERO) &&
                (ent[idx].dest == rd_addr2)) begin
                fwd_hit2  = 1'b1;
                fwd_data2 = ent[idx].data;
            end
        end
    end

    // Pending-destination mask over every buffered entry; r0 is never pending.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent[i].valid) begin
                pend_mask = pend_mask | reg_onehot(ent[i].dest);
            end
        end
        pend_mask[0] = 1'b0;
    end

    // Saturating count of accepted results that were filtered out.
    always_comb begin
        dropCnt_d = dropCnt_q;
        if (dropped && (dropCnt_q != 8'hFF)) begin
            dropCnt_d = dropCnt_q + 8'd1;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            dropCnt_q <= '0;
        end else begin
            dropCnt_q <= dropCnt_d;
        end
    end

    assign drop_cnt = dropCnt_q;

endmodule

// File: tb/tb_wb_writer.sv
// Self-checking bench for wb_writer: directed scenarios plus random traffic,
// compared against a queue-based reference of the buffered writes.
module tb_wb_writer;
    import wb_writer_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic          in_regwrite;
    logic          in_memtoreg;
    logic [AW-1:0] in_dest;
    logic [DW-1:0] in_alu;
    logic [DW-1:0] in_mem;
    logic          wr_grant;
    logic          wb_we;
    logic [AW-1:0] wb_dest;
    logic [DW-1:0] wb_data;
    logic [AW-1:0] rd_addr1;
    logic [AW-1:0] rd_addr2;
    logic          fwd_hit1;
    logic          fwd_hit2;
    logic [DW-1:0] fwd_data1;
    logic [DW-1:0] fwd_data2;
    logic [31:0]   pend_mask;
    logic [7:0]    drop_cnt;

    int checks = 0;
    int errors = 0;
    bit monOn  = 1'b0;
    bit fixRd  = 1'b0;

    typedef struct {
        logic [AW-1:0] dest;
        logic [DW-1:0] data;
    } wr_t;

    wr_t refQ[$];
    wr_t expQ[$];
    int  refDrop = 0;

    always #5 clk = ~clk;

    wb_writer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_regwrite (in_regwrite),
        .in_memtoreg (in_memtoreg),
        .in_dest     (in_dest),
        .in_alu      (in_alu),
        .in_mem      (in_mem),
        .wr_grant    (wr_grant),
        .wb_we       (wb_we),
        .wb_dest     (wb_dest),
        .wb_data     (wb_data),
        .rd_addr1    (rd_addr1),
        .rd_addr2    (rd_addr2),
        .fwd_hit1    (fwd_hit1),
        .fwd_hit2    (fwd_hit2),
        .fwd_data1   (fwd_data1),
        .fwd_data2   (fwd_data2),
        .pend_mask   (pend_mask),
        .drop_cnt    (drop_cnt)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then advance to just after the next rising edge.
    task automatic applyStimulus(input bit v, input bit rw, input bit m2r, input logic [AW-1:0] d,
                                 input logic [DW-1:0] alu, input logic [DW-1:0] mem, input bit g);
        in_valid    = v;
        in_regwrite = rw;
        in_memtoreg = m2r;
        in_dest     = d;
        in_alu      = alu;
        in_mem      = mem;
        wr_grant    = g;
        if (!fixRd) begin
            rd_addr1 = AW'($urandom_range(0, 20));
            rd_addr2 = AW'($urandom_range(0, 20));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit g);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, g);
    endtask

    // Reference model: what the block holds after each rising edge.
    always @(posedge clk) begin
        bit  acc;
        wr_t e;
        if (reset) begin
            refQ.delete();
            expQ.delete();
            refDrop = 0;
        end else begin
            acc = in_valid && (refQ.size() < DEPTH);
            if (wr_grant && refQ.size() > 0) void'(refQ.pop_front());
            if (acc) begin
                if (in_regwrite && in_dest != '0) begin
                    e.dest = in_dest;
                    e.data = in_memtoreg ? in_mem : in_alu;
                    refQ.push_back(e);
                    expQ.push_back(e);
                end else if (refDrop < 255) begin
                    refDrop++;
                end
            end
        end
    end

    // Monitor: compare every visible output mid-cycle; each issued write
    // consumes the oldest expected write from the scoreboard.
    always @(negedge clk) begin
        logic [31:0]   expPend;
        logic          expHit1, expHit2;
        logic [DW-1:0] expD1, expD2;
        wr_t           w;
        if (monOn) begin
            expPend = '0;
            expHit1 = 1'b0; expD1 = '0;
            expHit2 = 1'b0; expD2 = '0;
            foreach (refQ[k]) expPend[refQ[k].dest] = 1'b1;
            for (int k = refQ.size() - 1; k >= 0; k--) begin
                if (!expHit1 && rd_addr1 != '0 && refQ[k].dest == rd_addr1) begin
                    expHit1 = 1'b1; expD1 = refQ[k].data;
                end
                if (!expHit2 && rd_addr2 != '0 && refQ[k].dest == rd_addr2) begin
                    expHit2 = 1'b1; expD2 = refQ[k].data;
                end
            end
            checkOutput("in_ready", 64'(in_ready), 64'(refQ.size() < DEPTH));
            checkOutput("wb_we", 64'(wb_we), 64'(refQ.size() > 0 && wr_grant));
            checkOutput("pend_mask", 64'(pend_mask), 64'(expPend));
            checkOutput("fwd_hit1", 64'(fwd_hit1), 64'(expHit1));
            checkOutput("fwd_data1", 64'(fwd_data1), 64'(expD1));
            checkOutput("fwd_hit2", 64'(fwd_hit2), 64'(expHit2));
            checkOutput("fwd_data2", 64'(fwd_data2), 64'(expD2));
            checkOutput("drop_cnt", 64'(drop_cnt), 64'(refDrop));
            if (refQ.size() == 0) begin
                checkOutput("wb_dest_idle", 64'(wb_dest), 64'h0);
                checkOutput("wb_data_idle", 64'(wb_data), 64'h0);
            end
            if (wb_we === 1'b1) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write actual dest=%0d data=%0h required none", wb_dest, wb_data);
                end else begin
                    w = expQ.pop_front();
                    checkOutput("wb_dest", 64'(wb_dest), 64'(w.dest));
                    checkOutput("wb_data", 64'(wb_data), 64'(w.data));
                end
            end
        end
    end

    initial begin
        int budget;
        reset = 1'b1;
        in_valid = 0; in_regwrite = 0; in_memtoreg = 0; in_dest = '0;
        in_alu = '0; in_mem = '0; wr_grant = 0; rd_addr1 = '0; rd_addr2 = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        monOn = 1'b1;

        $display("[TB] reset and single write");
        idle(1, 1'b1);
        applyStimulus(1, 1, 0, 5'd5, 32'h1234, 32'h0, 1);
        idle(2, 1'b1);

        $display("[TB] filtering");
        applyStimulus(1, 1, 0, 5'd0, 32'hDEAD, 32'h0, 1);
        applyStimulus(1, 0, 0, 5'd7, 32'hBEEF, 32'h0, 1);
        idle(2, 1'b1);

        $display("[TB] back-pressure and full");
        for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, AW'(10 + i), 32'hA0 + i, 32'h0, 0);
        idle(6, 1'b1);

        $display("[TB] forwarding priority");
        fixRd = 1'b1;
        rd_addr1 = 5'd3;
        rd_addr2 = 5'd0;
        applyStimulus(1, 1, 0, 5'd3, 32'h11, 32'h0, 0);
        applyStimulus(1, 1, 1, 5'd3, 32'h99, 32'h22, 0);
        idle(2, 1'b0);
        rd_addr2 = 5'd3;
        idle(1, 1'b0);
        fixRd = 1'b0;
        idle(3, 1'b1);

        $display("[TB] simultaneous push/pop and wrap");
        for (int i = 1; i <= 20; i++) applyStimulus(1, 1, 0, AW'(i), 32'h100 + i, 32'h0, 1);
        idle(2, 1'b1);

        $display("[TB] reset mid-operation");
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, AW'(21 + i), 32'hC0 + i, 32'h0, 0);
        reset = 1'b1;
        idle(1, 1'b0);
        reset = 1'b0;
        idle(4, 1'b1);

        $display("[TB] drop counter saturation");
        for (int i = 0; i < 260; i++) applyStimulus(1, 0, 0, AW'($urandom_range(0, 31)), $urandom, $urandom, 1);
        idle(1, 1'b1);
        reset = 1'b1;
        idle(1, 1'b0);
        reset = 1'b0;

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8, 1'($urandom),
                          AW'($urandom_range(0, 7)), $urandom, $urandom, $urandom_range(0, 9) < 6);
        end

        budget = 0;
        while (refQ.size() > 0 && budget < 20) begin
            idle(1, 1'b1);
            budget++;
        end
        idle(1, 1'b1);
        checkOutput("drain_complete", 64'(expQ.size()), 64'h0);

        monOn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
